tube_host_initiator: RTL and testbench

//  Host-side bus initiator for the Tube ULA. Turns a valid/ready command stream (reg addr, rnw, data) into
//  6502-style host bus cycles (h_phi2/h_cs_b/h_rdnw/h_addr/h_data) and returns read data on a response channel.

---
 rtl/tube_host_pkg.sv | 35 +++
 rtl/tube_phi2_gen.sv | 49 ++++
 rtl/tube_host_initiator.sv | 224 ++++++++++++++++++++++
 tb/tb_tube_host_initiator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_host_pkg.sv
// Shared definitions for the Tube host-side initiator.
// Optional feature macro: STATUS_POLL_EN (adds the status-poll state).
package tube_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FALL,
    ST_ACCESS,
    ST_GAP,
    ST_RESP
`ifdef STATUS_POLL_EN
    , ST_POLL
`endif
  } state_t;

  // Status register bit positions: data available / space available.
  localparam int STAT_DA = 7;
  localparam int STAT_SA = 6;

  // Tube host register map: each FIFO has a status reg (even) and data reg (odd).
  localparam logic [2:0] REG_R1_STAT = 3'd0;
  localparam logic [2:0] REG_R1_DATA = 3'd1;
  localparam logic [2:0] REG_R2_STAT = 3'd2;
  localparam logic [2:0] REG_R2_DATA = 3'd3;
  localparam logic [2:0] REG_R3_STAT = 3'd4;
  localparam logic [2:0] REG_R3_DATA = 3'd5;
  localparam logic [2:0] REG_R4_STAT = 3'd6;
  localparam logic [2:0] REG_R4_DATA = 3'd7;

  // Status register paired with a data register.
  function automatic logic [2:0] status_addr(input logic [2:0] addr);
    return {addr[2:1], 1'b0};
  endfunction

endpackage

// File: rtl/tube_phi2_gen.sv
// Free-running phi2 generator: low CLK_DIV clocks, then high CLK_DIV clocks.
// fall_pulse / rise_pulse are one-clock strobes high in the first clock
// after the corresponding phi2 edge.
module tube_phi2_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic h_clk,
  input  logic h_rst,
  output logic h_phi2,
  output logic fall_pulse,
  output logic rise_pulse
);

  logic [7:0] div_q, div_d;
  logic       phi2_q, phi2_d;
  logic       fall_q, fall_d;
  logic       rise_q, rise_d;
  logic       wrap;

  assign wrap = (div_q == 8'(CLK_DIV - 1));

  // Next-state: count half-period, toggle phi2 and flag the edge direction.
  always_comb begin
    div_d  = wrap ? 8'd0 : div_q + 8'd1;
    phi2_d = wrap ? ~phi2_q : phi2_q;
    fall_d = wrap & phi2_q;
    rise_d = wrap & ~phi2_q;
  end

  // Divider and strobe registers.
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      div_q  <= 8'd0;
      phi2_q <= 1'b0;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      phi2_q <= phi2_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign h_phi2     = phi2_q;
  assign fall_pulse = fall_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/tube_host_initiator.sv
// Host-side bus initiator for the Tube ULA: command stream -> 6502-style
// bus cycles, read data returned on a response channel. Also synchronises
// the ULA interrupt. Define STATUS_POLL_EN to poll the status register
// before a data access.
module tube_host_initiator
  import tube_host_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int POLL_MAX = 64
) (
  input  logic       h_clk,
  input  logic       h_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_poll,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       h_phi2,
  output logic       h_cs_b,
  output logic       h_rdnw,
  output logic [2:0] h_addr,
  output logic [7:0] h_data_out,
  output logic       h_data_oe,
  input  logic [7:0] h_data_in,
  input  logic       h_irq_b,
  output logic       irq
);

  state_t     state_q, state_d;
  logic       rdy_en_q;
  logic       c_rnw_q, c_rnw_d;
  logic [2:0] c_addr_q, c_addr_d;
  logic [7:0] c_wdata_q, c_wdata_d;
  logic       cs_b_q, cs_b_d;
  logic       rdnw_q, rdnw_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic [7:0] rdata_q, rdata_d;
  logic       irq_meta_q, irq_q;
  logic       fall_pulse;
  logic       rise_unused;
  logic       poll_active;

`ifdef STATUS_POLL_EN
  logic       polling_q, polling_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic       timeout_q, timeout_d;
  assign poll_active = polling_q;
`else
  logic unused_cfg;
  assign poll_active = 1'b0;
  assign unused_cfg  = cmd_poll | (POLL_MAX == 0);
`endif

  tube_phi2_gen #(.CLK_DIV(CLK_DIV)) u_phi2 (
    .h_clk      (h_clk),
    .h_rst      (h_rst),
    .h_phi2     (h_phi2),
    .fall_pulse (fall_pulse),
    .rise_pulse (rise_unused)
  );

  // Ready is held low until the first clock after reset release.
  assign cmd_ready   = rdy_en_q & (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rsp_valid ? rdata_q : 8'h00;
`ifdef STATUS_POLL_EN
  assign rsp_timeout = rsp_valid & timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign h_cs_b     = cs_b_q;
  assign h_rdnw     = rdnw_q;
  assign h_addr     = addr_q;
  assign h_data_out = dout_q;
  assign h_data_oe  = oe_q;
  assign irq        = irq_q;

  // Bus-cycle sequencer: all bus outputs change one clock after a phi2 fall.
  always_comb begin
    state_d   = state_q;
    c_rnw_d   = c_rnw_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    cs_b_d    = cs_b_q;
    rdnw_d    = rdnw_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    rdata_d   = rdata_q;
`ifdef STATUS_POLL_EN
    polling_d  = polling_q;
    poll_cnt_d = poll_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          c_rnw_d   = cmd_rnw;
          c_addr_d  = cmd_addr;
          c_wdata_d = cmd_wdata;
          rdata_d   = 8'h00;
`ifdef STATUS_POLL_EN
          polling_d  = cmd_poll;
          poll_cnt_d = 8'd0;
          timeout_d  = 1'b0;
`endif
          state_d   = ST_WAIT_FALL;
        end
      end
      ST_WAIT_FALL: begin
        if (fall_pulse) begin
          state_d = ST_ACCESS;
          cs_b_d  = 1'b0;
          if (poll_active) begin
            addr_d = status_addr(c_addr_q);
            rdnw_d = 1'b1;
          end else begin
            addr_d = c_addr_q;
            rdnw_d = c_rnw_q;
            dout_d = c_rnw_q ? 8'h00 : c_wdata_q;
            oe_d   = ~c_rnw_q;
          end
        end
      end
      ST_ACCESS: begin
        // Data is stable over the whole low half after the fall.
        if (fall_pulse) begin
          rdata_d = rdnw_q ? h_data_in : 8'h00;
          cs_b_d  = 1'b1;
          rdnw_d  = 1'b1;
          addr_d  = 3'd0;
          dout_d  = 8'h00;
          oe_d    = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // The ULA needs a full deselected phi2 period between accesses.
        if (fall_pulse) begin
`ifdef STATUS_POLL_EN
          state_d = polling_q ? ST_POLL : ST_RESP;
`else
          state_d = ST_RESP;
`endif
        end
      end
`ifdef STATUS_POLL_EN
      ST_POLL: begin
        if (c_rnw_q ? rdata_q[STAT_DA] : rdata_q[STAT_SA]) begin
          polling_d = 1'b0;
          state_d   = ST_WAIT_FALL;
        end else if (poll_cnt_q + 8'd1 == 8'(POLL_MAX)) begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          timeout_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          state_d    = ST_WAIT_FALL;
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      state_q   <= ST_IDLE;
      rdy_en_q  <= 1'b0;
      c_rnw_q   <= 1'b1;
      c_addr_q  <= 3'd0;
      c_wdata_q <= 8'h00;
      cs_b_q    <= 1'b1;
      rdnw_q    <= 1'b1;
      addr_q    <= 3'd0;
      dout_q    <= 8'h00;
      oe_q      <= 1'b0;
      rdata_q   <= 8'h00;
`ifdef STATUS_POLL_EN
      polling_q  <= 1'b0;
      poll_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      c_rnw_q   <= c_rnw_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      cs_b_q    <= cs_b_d;
      rdnw_q    <= rdnw_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      rdata_q   <= rdata_d;
`ifdef STATUS_POLL_EN
      polling_q  <= polling_d;
      poll_cnt_q <= poll_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Two-flop synchroniser for the asynchronous active-low ULA interrupt.
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      irq_meta_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_meta_q <= ~h_irq_b;
      irq_q      <= irq_meta_q;
    end
  end

endmodule

// File: tb/tb_tube_host_initiator.sv
// Directed testbench for tube_host_initiator (default parameters:
// CLK_DIV=4 -> 8-clock phi2 period, POLL_MAX=64).
module tb_tube_host_initiator;
  import tube_host_pkg::*;

  logic       h_clk = 1'b0;
  logic       h_rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rnw = 1'b1;
  logic [2:0] cmd_addr = 3'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_poll = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       h_phi2, h_cs_b, h_rdnw, h_data_oe, irq;
  logic [2:0] h_addr;
  logic [7:0] h_data_out, h_data_in;
  logic       h_irq_b = 1'b1;

  // ULA model: fixed data registers, programmable status behaviour.
  logic [7:0] rd_val [8];
  logic       stat_mode = 1'b0;
  int         stat_base = 0;
  int         stat_need = 0;
  logic [7:0] stat_val;

  int checks = 0;
  int errors = 0;

  tube_host_initiator dut (
    .h_clk(h_clk), .h_rst(h_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_poll(cmd_poll),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .h_phi2(h_phi2), .h_cs_b(h_cs_b), .h_rdnw(h_rdnw), .h_addr(h_addr),
    .h_data_out(h_data_out), .h_data_oe(h_data_oe), .h_data_in(h_data_in),
    .h_irq_b(h_irq_b), .irq(irq)
  );

  always #5 h_clk = ~h_clk;

  // Bus monitor, sampled on the falling clock edge.
  logic       cs_p = 1'b1, phi_p1 = 1'b0, phi_p2 = 1'b0;
  int         cs_run = 0, last_cs_len = 0, gap_run = 0, last_gap = 0;
  int         acc_cnt = 0, wr_cnt = 0, stat_reads = 0, oe_cnt = 0;
  int         rsp_cnt = 0, rsp_run = 0, last_rsp_len = 0;
  int         phi_run = 0, last_phi_hi = 0, xfer_cnt = 0;
  int         xfer_snap [16];
  logic [2:0] st_addr = 3'd0;
  logic       st_rdnw = 1'b1, st_oe = 1'b0, st_align = 1'b0;
  logic [7:0] st_dout = 8'h00;

  always_comb begin
    stat_val = 8'h00;
    if (stat_reads - stat_base >= stat_need) stat_val = 8'hC0;
  end
  assign h_data_in = (stat_mode && !h_addr[0]) ? stat_val : rd_val[h_addr];

  always @(negedge h_clk) begin
    cs_p   <= h_cs_b;
    phi_p1 <= h_phi2;
    phi_p2 <= phi_p1;
    if (!h_cs_b) begin
      if (cs_p) begin
        cs_run   <= 1;
        acc_cnt  <= acc_cnt + 1;
        last_gap <= gap_run;
        st_addr  <= h_addr;
        st_rdnw  <= h_rdnw;
        st_oe    <= h_data_oe;
        st_dout  <= h_data_out;
        st_align <= phi_p2 & ~phi_p1 & ~h_phi2;
        if (!h_rdnw) wr_cnt <= wr_cnt + 1;
        else if (!h_addr[0]) stat_reads <= stat_reads + 1;
      end else begin
        cs_run <= cs_run + 1;
      end
    end else begin
      if (!cs_p) begin
        last_cs_len <= cs_run;
        gap_run     <= 1;
      end else begin
        gap_run <= gap_run + 1;
      end
    end
    if (h_data_oe) oe_cnt <= oe_cnt + 1;
    if (h_phi2) phi_run <= phi_run + 1;
    else begin
      if (phi_run != 0) last_phi_hi <= phi_run;
      phi_run <= 0;
    end
    if (rsp_valid) begin
      rsp_run <= rsp_run + 1;
      if (rsp_run == 0) rsp_cnt <= rsp_cnt + 1;
    end else begin
      if (rsp_run != 0) last_rsp_len <= rsp_run;
      rsp_run <= 0;
    end
    if (cmd_valid && cmd_ready) begin
      if (xfer_cnt < 16) xfer_snap[xfer_cnt] <= rsp_cnt;
      xfer_cnt <= xfer_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a command and return once it has been transferred.
  task automatic issue(input logic rnw, input logic [2:0] a, input logic [7:0] wd, input logic pl);
    int n;
    @(posedge h_clk); #1;
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = wd; cmd_poll = pl;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(posedge h_clk); #1;
      n++;
    end
    check("cmd_accepted", {31'd0, cmd_ready}, 32'd1);
    @(posedge h_clk); #1;
    cmd_valid = 1'b0; cmd_poll = 1'b0;
  endtask

  // Wait for the response pulse, then one more clock so monitor totals settle.
  task automatic wait_rsp(output logic [7:0] rd, output logic to);
    int n;
    n = 0;
    rd = 8'h00; to = 1'b0;
    do begin
      @(negedge h_clk);
      n++;
    end while (!rsp_valid && n < 5000);
    check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    to = rsp_timeout;
    @(negedge h_clk); #1;
  endtask

  logic [7:0] rd;
  logic       to;
  int         a0, w0, r0, o0, x0, s0;
  logic [4:0] irq_hist;

  initial begin
    for (int i = 0; i < 8; i++) rd_val[i] = 8'h10 + 8'(i);
    rd_val[REG_R3_DATA] = 8'h5A;

    // Reset values while reset is held.
    repeat (3) @(negedge h_clk);
    #1;
    check("rst_phi2", {31'd0, h_phi2}, 32'd0);
    check("rst_cs_b", {31'd0, h_cs_b}, 32'd1);
    check("rst_rdnw", {31'd0, h_rdnw}, 32'd1);
    check("rst_addr", {29'd0, h_addr}, 32'd0);
    check("rst_dout", {24'd0, h_data_out}, 32'd0);
    check("rst_oe", {31'd0, h_data_oe}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp", {22'd0, rsp_valid, rsp_rdata, rsp_timeout}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge h_clk); h_rst = 1'b0; #1;
    check("ready_at_release", {31'd0, cmd_ready}, 32'd0);
    @(negedge h_clk); #1;
    check("ready_after_clk", {31'd0, cmd_ready}, 32'd1);

    // Write 0xAA to R1 data.
    w0 = wr_cnt; r0 = rsp_cnt;
    issue(1'b0, REG_R1_DATA, 8'hAA, 1'b0);
    wait_rsp(rd, to);
    check("wr_cs_len", last_cs_len, 32'd8);
    check("wr_align", {31'd0, st_align}, 32'd1);
    check("wr_rdnw", {31'd0, st_rdnw}, 32'd0);
    check("wr_addr", {29'd0, st_addr}, 32'd1);
    check("wr_data", {24'd0, st_dout}, 32'hAA);
    check("wr_oe", {31'd0, st_oe}, 32'd1);
    check("wr_count", wr_cnt - w0, 32'd1);
    check("wr_rdata", {24'd0, rd}, 32'd0);
    check("wr_rsp_count", rsp_cnt - r0, 32'd1);
    check("wr_rsp_len", last_rsp_len, 32'd1);
    check("phi2_high_len", last_phi_hi, 32'd4);

    // Read R3 data (reg5).
    o0 = oe_cnt;
    issue(1'b1, REG_R3_DATA, 8'h00, 1'b0);
    wait_rsp(rd, to);
    check("rd_rdata", {24'd0, rd}, 32'h5A);
    check("rd_oe_never", oe_cnt - o0, 32'd0);
    check("rd_rdnw", {31'd0, st_rdnw}, 32'd1);
    check("rd_addr", {29'd0, st_addr}, 32'd5);
    check("rd_cs_len", last_cs_len, 32'd8);
    check("rd_timeout", {31'd0, to}, 32'd0);

    // Back-to-back: write R4 then read R1; second waits for first response.
    x0 = xfer_cnt;
    issue(1'b0, REG_R4_DATA, 8'h77, 1'b0);
    issue(1'b1, REG_R1_DATA, 8'h00, 1'b0);
    wait_rsp(rd, to);
    check("b2b_rdata", {24'd0, rd}, 32'h11);
    check("b2b_gap", last_gap, 32'd16);
    check("b2b_accept_after_rsp", xfer_snap[x0 + 1] - xfer_snap[x0], 32'd1);

    // Reset pulsed in the middle of a write access.
    issue(1'b0, REG_R2_DATA, 8'h33, 1'b0);
    begin
      int n;
      n = 0;
      while (h_cs_b && n < 100) begin
        @(negedge h_clk);
        n++;
      end
    end
    check("rst_mid_cs_seen", {31'd0, h_cs_b}, 32'd0);
    repeat (2) @(negedge h_clk);
    r0 = rsp_cnt;
    h_rst = 1'b1; #1;
    check("rst_mid_cs_b", {31'd0, h_cs_b}, 32'd1);
    check("rst_mid_oe", {31'd0, h_data_oe}, 32'd0);
    check("rst_mid_phi2", {31'd0, h_phi2}, 32'd0);
    check("rst_mid_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge h_clk); h_rst = 1'b0;
    repeat (40) @(negedge h_clk);
    #1;
    check("rst_mid_no_rsp", rsp_cnt - r0, 32'd0);
    issue(1'b1, REG_R3_DATA, 8'h00, 1'b0);
    wait_rsp(rd, to);
    check("rst_mid_next_rdata", {24'd0, rd}, 32'h5A);

`ifdef STATUS_POLL_EN
    // Poll write to R2: status SA bit clear for 3 reads, set on the 4th.
    stat_mode = 1'b1;
    s0 = stat_reads; w0 = wr_cnt;
    stat_base = stat_reads; stat_need = 4;
    issue(1'b0, REG_R2_DATA, 8'h3C, 1'b1);
    wait_rsp(rd, to);
    check("poll_stat_reads", stat_reads - s0, 32'd4);
    check("poll_wr_count", wr_cnt - w0, 32'd1);
    check("poll_wr_data", {24'd0, st_dout}, 32'h3C);
    check("poll_timeout", {31'd0, to}, 32'd0);
    check("poll_rdata", {24'd0, rd}, 32'd0);
    // SA stuck clear: give up after POLL_MAX status reads.
    s0 = stat_reads; w0 = wr_cnt;
    stat_base = stat_reads; stat_need = 1000;
    issue(1'b0, REG_R2_DATA, 8'h3C, 1'b1);
    wait_rsp(rd, to);
    check("stuck_stat_reads", stat_reads - s0, 32'd64);
    check("stuck_wr_count", wr_cnt - w0, 32'd0);
    check("stuck_timeout", {31'd0, to}, 32'd1);
    check("stuck_rdata", {24'd0, rd}, 32'd0);
    stat_mode = 1'b0;
`else
    // Without polling support cmd_poll is ignored: a single data access.
    a0 = acc_cnt; s0 = stat_reads;
    issue(1'b1, REG_R3_DATA, 8'h00, 1'b1);
    wait_rsp(rd, to);
    check("nopoll_acc_count", acc_cnt - a0, 32'd1);
    check("nopoll_stat_reads", stat_reads - s0, 32'd0);
    check("nopoll_rdata", {24'd0, rd}, 32'h5A);
    check("nopoll_timeout", {31'd0, to}, 32'd0);
`endif

    // Interrupt: low for 3 clocks -> irq high for 3 clocks, 2 clocks later.
    @(negedge h_clk); h_irq_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge h_clk);
      if (i == 2) h_irq_b = 1'b1;
      irq_hist[4 - i] = irq;
    end
    check("irq_sync", {27'd0, irq_hist}, 32'b01110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
